// File: rtl/sram_pkg.sv
// Shared types and constants for the wait-state SRAM model (sram_ws).
// Optional access-error reporting is enabled by SRAM_ACCESS_ERR_EN.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned DEF_RD_WAIT = 1;
    localparam int unsigned DEF_WR_WAIT = 2;

    function automatic int unsigned lane_count(input int unsigned data_w,
                                               input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/sram_ws_if.sv
// Bus bundle between memory controller (master) and sram_ws (slave).
// The err signal exists only when SRAM_ACCESS_ERR_EN is defined.
interface sram_ws_if
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LANES = lane_count(DATA_W, BYTE_W);

    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic [LANES-1:0]  be_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              ack;
    logic              busy;
`ifdef SRAM_ACCESS_ERR_EN
    logic              err;
`endif

    modport master (
        output ce_n, oe_n, we_n, be_n, addr, din,
`ifdef SRAM_ACCESS_ERR_EN
        input  err,
`endif
        input  dout, ack, busy
    );

    modport slave (
        input  ce_n, oe_n, we_n, be_n, addr, din,
`ifdef SRAM_ACCESS_ERR_EN
        output err,
`endif
        output dout, ack, busy
    );

endinterface

// File: rtl/sram_ws_ctrl.sv
// Access sequencer for sram_ws: FSM, wait counter, latch/commit strobes, ack/busy.
// With SRAM_ACCESS_ERR_EN an err pulse follows any abort or out-of-range completion.
module sram_ws_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce_n_i,
    input  logic oe_n_i,
    input  logic we_n_i,
`ifdef SRAM_ACCESS_ERR_EN
    input  logic in_range_i,
    output logic err_o,
`endif
    output logic accept_o,
    output logic wr_commit_o,
    output logic rd_load_o,
    output logic ack_o,
    output logic busy_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic               abort;
    logic               wr_req;
    logic               rd_req;

    // Write decode dominates, so a falling we_n during a read also changes the decode.
    assign wr_req = !ce_n_i && !we_n_i;
    assign rd_req = !ce_n_i && we_n_i && !oe_n_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        abort       = 1'b0;
        accept_o    = 1'b0;
        wr_commit_o = 1'b0;
        rd_load_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d  = WRITE;
                    cnt_d    = CNT_W'(1);
                    accept_o = 1'b1;
                end else if (rd_req) begin
                    state_d  = READ;
                    cnt_d    = CNT_W'(1);
                    accept_o = 1'b1;
                end
            end
            WRITE: begin
                if (!wr_req) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WR_WAIT)) begin
                    wr_commit_o = 1'b1;
                    ack_d       = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ: begin
                if (!rd_req) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(RD_WAIT)) begin
                    rd_load_o = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = (state_q != IDLE);

`ifdef SRAM_ACCESS_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort || ((wr_commit_o || rd_load_o) && !in_range_i);
        end
    end

    assign err_o = err_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: rtl/sram_ws.sv
// Parametrised wait-state-accurate SRAM model: array, byte-lane masking, dout register.
// Define SRAM_ACCESS_ERR_EN to add the err output on the bus interface.
module sram_ws
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BYTE_W  = 8,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DEPTH   = 2 ** ADDR_W,
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT
) (
    input  logic     clk,
    input  logic     rst_n,
    sram_ws_if.slave bus
);

    localparam int unsigned LANES = lane_count(DATA_W, BYTE_W);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [LANES-1:0]  be_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] lane_mask;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              accept;
    logic              wr_commit;
    logic              rd_load;
    logic              ack;
    logic              busy;

    sram_ws_ctrl #(
        .RD_WAIT (RD_WAIT),
        .WR_WAIT (WR_WAIT)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce_n_i      (bus.ce_n),
        .oe_n_i      (bus.oe_n),
        .we_n_i      (bus.we_n),
`ifdef SRAM_ACCESS_ERR_EN
        .in_range_i  (in_range),
        .err_o       (bus.err),
`endif
        .accept_o    (accept),
        .wr_commit_o (wr_commit),
        .rd_load_o   (rd_load),
        .ack_o       (ack),
        .busy_o      (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            din_q  <= '0;
            be_q   <= '1;
        end else if (accept) begin
            addr_q <= bus.addr;
            be_q   <= bus.be_n;
            if (!bus.we_n) begin
                din_q <= bus.din;
            end
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_mask[l*BYTE_W +: BYTE_W] = {BYTE_W{~be_q[l]}};
        end
    end

    // Range check on the full latched address; the index only uses the low bits.
    assign in_range = (64'(addr_q) < 64'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_commit && in_range) begin
            mem_q[idx] <= (mem_q[idx] & ~lane_mask) | (din_q & lane_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else if (rd_load) begin
            dout_q <= in_range ? (mem_q[idx] & lane_mask) : '0;
        end
    end

    assign bus.dout = dout_q;
    assign bus.ack  = ack;
    assign bus.busy = busy;

endmodule
